// File: rtl/evt_link_pkg.sv
// Shared definitions for the toggle-encoded event link: default synchroniser
// depth, counter width helper and the pending-counter update encoding.
package evt_link_pkg;

    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2,
        CNT_DROP = 2'd3
    } cnt_op_e;

    // Bits needed to represent every value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/toggle_evt_decoder_if.sv
// Consumer-side event handshake and status bundle of the toggle event decoder.
interface toggle_evt_decoder_if
    import evt_link_pkg::*;
#(
    parameter int MAX_PENDING = 7
);
    localparam int CW = cnt_width(MAX_PENDING);

    logic          evt_valid;
    logic          evt_ready;
    logic [CW-1:0] pending_cnt;
    logic          overflow;
    logic          overflow_clr;

    modport master (
        output evt_valid,
        output pending_cnt,
        output overflow,
        input  evt_ready,
        input  overflow_clr
    );

    modport slave (
        input  evt_valid,
        input  pending_cnt,
        input  overflow,
        output evt_ready,
        output overflow_clr
    );

endinterface

// File: rtl/toggle_edge_detect.sv
// Synchronises the asynchronous toggle line and flags one cycle per transition.
module toggle_edge_detect
    import evt_link_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic sync_reset,
    input  logic tgl_in,
    output logic detect
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    // Shift the raw line through the chain; history trails the last stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], tgl_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Chain and history reset to 0, so a high line at release reads as one event.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign detect = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/toggle_evt_decoder.sv
// Receive end of the toggle event link: queues recovered events in a saturating
// counter, hands them out on valid/ready and echoes an acknowledge toggle.
module toggle_evt_decoder
    import evt_link_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int MAX_PENDING = 7
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic                  tgl_in,
    output logic                  ack_tgl,
    toggle_evt_decoder_if.master  evt_if
);

    localparam int            CW      = cnt_width(MAX_PENDING);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING);

    logic          detect_s;
    logic          accept_s;
    cnt_op_e       op_s;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          ack_q;
    logic          ack_d;

    toggle_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk        (clk),
        .sync_reset (sync_reset),
        .tgl_in     (tgl_in),
        .detect     (detect_s)
    );

    assign accept_s = evt_if.evt_valid & evt_if.evt_ready;

    // Classify the edge, then derive counter, sticky drop flag and ack toggle.
    always_comb begin
        op_s  = CNT_HOLD;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        ack_d = ack_q ^ accept_s;

        case ({detect_s, accept_s})
            2'b10:   op_s = (cnt_q == CNT_MAX) ? CNT_DROP : CNT_INC;
            2'b01:   op_s = CNT_DEC;
            default: op_s = CNT_HOLD;
        endcase

        case (op_s)
            CNT_INC:  cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            CNT_DEC:  cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            CNT_DROP: cnt_d = cnt_q;
            default:  cnt_d = cnt_q;
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        if (op_s == CNT_DROP) begin
            ovf_d = 1'b1;
        end else if (evt_if.overflow_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers; reset discards queued events without flipping the ack.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            ack_q <= ack_d;
        end
    end

    assign evt_if.pending_cnt = cnt_q;
    assign evt_if.evt_valid   = (cnt_q != '0);
    assign evt_if.overflow    = ovf_q;
    assign ack_tgl            = ack_q;

endmodule

// File: tb/tb_toggle_evt_decoder.sv
// Directed self-checking bench for toggle_evt_decoder at default parameters.
module tb_toggle_evt_decoder;

    logic clk;
    logic sync_reset;
    logic tgl_in;
    logic ack_tgl;
    int   errors;
    int   checks;

    toggle_evt_decoder_if #(.MAX_PENDING(7)) evt_if ();

    toggle_evt_decoder #(
        .SYNC_STAGES (2),
        .MAX_PENDING (7)
    ) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .tgl_in     (tgl_in),
        .ack_tgl    (ack_tgl),
        .evt_if     (evt_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        sync_reset = 1'b1;
        tgl_in = 1'b0;
        evt_if.evt_ready = 1'b0;
        evt_if.overflow_clr = 1'b0;

        // Reset and first-event latency
        step(1);
        chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
        chk("rst_ack", 32'(ack_tgl), 32'd0);
        step(1);
        chk("rst_cnt", 32'(evt_if.pending_cnt), 32'd0);
        chk("rst_ovf", 32'(evt_if.overflow), 32'd0);
        sync_reset = 1'b0;
        step(1);
        tgl_in = 1'b1;
        step(2);
        chk("lat_valid_early", 32'(evt_if.evt_valid), 32'd0);
        step(1);
        chk("lat_valid", 32'(evt_if.evt_valid), 32'd1);
        chk("lat_cnt", 32'(evt_if.pending_cnt), 32'd1);
        step(2);
        chk("lat_cnt_hold", 32'(evt_if.pending_cnt), 32'd1);

        // Queue three, then drain with ready held high
        tgl_in = 1'b0;
        step(4);
        tgl_in = 1'b1;
        step(4);
        chk("q3_cnt", 32'(evt_if.pending_cnt), 32'd3);
        evt_if.evt_ready = 1'b1;
        step(1);
        chk("drain_cnt2", 32'(evt_if.pending_cnt), 32'd2);
        chk("drain_ack1", 32'(ack_tgl), 32'd1);
        step(1);
        chk("drain_cnt1", 32'(evt_if.pending_cnt), 32'd1);
        chk("drain_ack0", 32'(ack_tgl), 32'd0);
        step(1);
        chk("drain_cnt0", 32'(evt_if.pending_cnt), 32'd0);
        chk("drain_ack1b", 32'(ack_tgl), 32'd1);
        chk("drain_valid", 32'(evt_if.evt_valid), 32'd0);
        step(1);
        chk("idle_ready_cnt", 32'(evt_if.pending_cnt), 32'd0);
        chk("idle_ready_ack", 32'(ack_tgl), 32'd1);
        evt_if.evt_ready = 1'b0;

        // Detect and accept in the same cycle
        tgl_in = 1'b0;
        step(4);
        tgl_in = 1'b1;
        step(4);
        chk("sim_pre_cnt", 32'(evt_if.pending_cnt), 32'd2);
        tgl_in = 1'b0;
        step(2);
        evt_if.evt_ready = 1'b1;
        step(1);
        evt_if.evt_ready = 1'b0;
        chk("sim_cnt", 32'(evt_if.pending_cnt), 32'd2);
        chk("sim_ack", 32'(ack_tgl), 32'd0);
        step(2);
        chk("sim_cnt_after", 32'(evt_if.pending_cnt), 32'd2);

        // Empty the queue, then overflow it with nine events
        evt_if.evt_ready = 1'b1;
        step(2);
        evt_if.evt_ready = 1'b0;
        chk("pre_ovf_cnt", 32'(evt_if.pending_cnt), 32'd0);
        chk("pre_ovf_ack", 32'(ack_tgl), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            tgl_in = ~tgl_in;
            step(4);
            chk($sformatf("ovf_cnt_%0d", i), 32'(evt_if.pending_cnt), (i > 7) ? 32'd7 : 32'(i));
            chk($sformatf("ovf_flag_%0d", i), 32'(evt_if.overflow), (i >= 8) ? 32'd1 : 32'd0);
        end
        evt_if.evt_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk($sformatf("ovf_drain_%0d", i), 32'(evt_if.pending_cnt), 32'(7 - i));
        end
        step(1);
        evt_if.evt_ready = 1'b0;
        chk("ovf_drain_end", 32'(evt_if.pending_cnt), 32'd0);
        chk("ovf_drain_ack", 32'(ack_tgl), 32'd1);
        chk("ovf_sticky", 32'(evt_if.overflow), 32'd1);

        // Clear alone, then clear colliding with a drop
        evt_if.overflow_clr = 1'b1;
        step(1);
        evt_if.overflow_clr = 1'b0;
        chk("clr_plain", 32'(evt_if.overflow), 32'd0);
        for (int i = 0; i < 7; i++) begin
            tgl_in = ~tgl_in;
            step(4);
        end
        chk("fill_cnt", 32'(evt_if.pending_cnt), 32'd7);
        chk("fill_ovf", 32'(evt_if.overflow), 32'd0);
        tgl_in = ~tgl_in;
        step(2);
        evt_if.overflow_clr = 1'b1;
        step(1);
        evt_if.overflow_clr = 1'b0;
        chk("clr_vs_drop", 32'(evt_if.overflow), 32'd1);
        chk("clr_vs_drop_cnt", 32'(evt_if.pending_cnt), 32'd7);
        step(1);
        evt_if.overflow_clr = 1'b1;
        step(1);
        evt_if.overflow_clr = 1'b0;
        chk("clr_after", 32'(evt_if.overflow), 32'd0);

        // Reset mid-operation with the line held high
        tgl_in = ~tgl_in;
        step(4);
        chk("mid_pre_ovf", 32'(evt_if.overflow), 32'd1);
        evt_if.evt_ready = 1'b1;
        step(2);
        evt_if.evt_ready = 1'b0;
        chk("mid_pre_cnt", 32'(evt_if.pending_cnt), 32'd5);
        chk("mid_pre_ack", 32'(ack_tgl), 32'd1);
        sync_reset = 1'b1;
        tgl_in = 1'b1;
        step(1);
        sync_reset = 1'b0;
        chk("mid_cnt", 32'(evt_if.pending_cnt), 32'd0);
        chk("mid_valid", 32'(evt_if.evt_valid), 32'd0);
        chk("mid_ovf", 32'(evt_if.overflow), 32'd0);
        chk("mid_ack", 32'(ack_tgl), 32'd0);
        step(2);
        chk("mid_valid_early", 32'(evt_if.evt_valid), 32'd0);
        step(1);
        chk("mid_evt_valid", 32'(evt_if.evt_valid), 32'd1);
        chk("mid_evt_cnt", 32'(evt_if.pending_cnt), 32'd1);
        step(3);
        chk("mid_evt_once", 32'(evt_if.pending_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
